// File: rtl/constraint_stim_gen.sv
// constraint_stim_gen: LFSR-driven generator of (a,b) pairs satisfying (a==0)||(b!=0),
// streamed over valid/ready with rejection sampling and a bounded retry budget.
module constraint_stim_gen #(
    parameter int          A_W       = 15,
    parameter int          B_W       = 12,
    parameter logic [31:0] SEED      = 32'hACE12468,
    parameter int          MAX_TRIES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [15:0]    count,
    input  logic [1:0]     mode,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [A_W-1:0] out_a,
    output logic [B_W-1:0] out_b,
    output logic           done,
    output logic           fail,
    output logic [15:0]    rej_cnt
);
    typedef enum logic [1:0] {IDLE, GEN, HOLD, DONE} state_t;
    localparam int          TW   = $clog2(MAX_TRIES + 1);
    localparam logic [31:0] TAPS = 32'h80200003;

    state_t         state_q, state_d;
    logic [31:0]    lfsr_q, lfsr_d, lfsr_nxt;
    logic [15:0]    remaining_q, remaining_d;
    logic [15:0]    rej_q, rej_d;
    logic [1:0]     mode_q, mode_d;
    logic [TW-1:0]  tries_q, tries_d;
    logic           fail_q, fail_d;
    logic           valid_q, valid_d;
    logic [A_W-1:0] a_q, a_d, cand_a;
    logic [B_W-1:0] b_q, b_d, cand_b;
    logic           sat;

    always_comb begin
        cand_a   = mode_q[1] ? '0 : lfsr_q[A_W-1:0];
        cand_b   = mode_q[0] ? '0 : lfsr_q[31:32-B_W];
        sat      = (cand_a == '0) || (cand_b != '0);
        lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        remaining_d = remaining_q;
        rej_d       = rej_q;
        mode_d      = mode_q;
        tries_d     = tries_q;
        fail_d      = fail_q;
        valid_d     = valid_q;
        a_d         = a_q;
        b_d         = b_q;
        case (state_q)
            IDLE: if (start) begin
                remaining_d = count;
                mode_d      = mode;
                lfsr_d      = SEED;
                tries_d     = '0;
                rej_d       = '0;
                fail_d      = 1'b0;
                state_d     = (count == 16'd0) ? DONE : GEN;
            end
            GEN: begin
                lfsr_d = lfsr_nxt;
                if (sat) begin
                    a_d     = cand_a;
                    b_d     = cand_b;
                    valid_d = 1'b1;
                    tries_d = '0;
                    state_d = HOLD;
                end else begin
                    rej_d   = (rej_q == 16'hFFFF) ? rej_q : rej_q + 16'd1;
                    tries_d = tries_q + TW'(1);
                    if (tries_q == TW'(MAX_TRIES - 1)) begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            HOLD: if (out_ready) begin
                valid_d     = 1'b0;
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q == 16'd1) ? DONE : GEN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            remaining_q <= '0;
            rej_q       <= '0;
            mode_q      <= '0;
            tries_q     <= '0;
            fail_q      <= 1'b0;
            valid_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            remaining_q <= remaining_d;
            rej_q       <= rej_d;
            mode_q      <= mode_d;
            tries_q     <= tries_d;
            fail_q      <= fail_d;
            valid_q     <= valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign fail      = fail_q;
    assign rej_cnt   = rej_q;
endmodule

// File: tb/tb_constraint_stim_gen.sv
// tb_constraint_stim_gen: directed scenario tasks for constraint_stim_gen, checked against
// a reference LFSR walk from SEED.
module tb_constraint_stim_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] count = '0;
    logic [1:0]  mode = '0;
    logic        out_ready = 1'b0;
    logic        busy, out_valid, done, fail;
    logic [14:0] out_a;
    logic [11:0] out_b;
    logic [15:0] rej_cnt;

    int total = 0;
    int bad = 0;
    logic [14:0] exp_a [0:7];
    logic [11:0] exp_b [0:7];
    int exp_rej;

    constraint_stim_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count), .mode(mode),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .done(done), .fail(fail), .rej_cnt(rej_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Expected accepted pairs and total rejections when walking the LFSR from SEED.
    task automatic build(input logic [1:0] md, input int n);
        logic [31:0] s = 32'hACE12468;
        logic [14:0] ca;
        logic [11:0] cb;
        int k = 0;
        int tries = 0;
        exp_rej = 0;
        while (k < n && tries < 16) begin
            ca = md[1] ? 15'd0 : s[14:0];
            cb = md[0] ? 12'd0 : s[31:20];
            s = lfsr_step(s);
            if (ca == 15'd0 || cb != 12'd0) begin
                exp_a[k] = ca;
                exp_b[k] = cb;
                k++;
                tries = 0;
            end else begin
                exp_rej++;
                tries++;
            end
        end
    endtask

    task automatic do_start(input logic [15:0] cnt, input logic [1:0] md);
        @(negedge clk);
        start = 1'b1;
        count = cnt;
        mode  = md;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int n, input string name);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) begin
                total++;
                if (out_a !== exp_a[k] || out_b !== exp_b[k]) begin
                    bad++;
                    $display("FAIL %s pair%0d: got a=%h b=%h, want a=%h b=%h", name, k, out_a, out_b, exp_a[k], exp_b[k]);
                end
                total++;
                if (!(out_a == 15'd0 || out_b != 12'd0)) begin
                    bad++;
                    $display("FAIL %s sat%0d: a=%h b=%h violates constraint", name, k, out_a, out_b);
                end
                k++;
            end
        end
        total++;
        if (k != n) begin
            bad++;
            $display("FAIL %s transfers: got %0d, want %0d", name, k, n);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s done: got %b, want 1", name, done);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s done_end: done=%b busy=%b, want 0 0", name, done, busy);
        end
        total++;
        if (rej_cnt !== 16'(exp_rej)) begin
            bad++;
            $display("FAIL %s rej_cnt: got %0d, want %0d", name, rej_cnt, exp_rej);
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (busy !== 0 || out_valid !== 0 || done !== 0 || fail !== 0 || out_a !== 0 || out_b !== 0 || rej_cnt !== 0) begin
            bad++;
            $display("FAIL reset: busy=%b valid=%b done=%b fail=%b a=%h b=%h rej=%0d, want all 0", busy, out_valid, done, fail, out_a, out_b, rej_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal;
        out_ready = 1'b1;
        build(2'b00, 4);
        do_start(16'd4, 2'b00);
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency: busy=%b valid=%b at t+1, want 1 0", busy, out_valid);
        end
        collect(4, "normal");
    endtask

    task automatic test_force_a;
        out_ready = 1'b1;
        build(2'b10, 3);
        do_start(16'd3, 2'b10);
        collect(3, "force_a");
        total++;
        if (fail !== 1'b0 || rej_cnt !== 16'd0) begin
            bad++;
            $display("FAIL force_a flags: fail=%b rej=%0d, want 0 0", fail, rej_cnt);
        end
    endtask

    task automatic test_fail;
        int n = 0;
        logic seen = 1'b0;
        out_ready = 1'b1;
        do_start(16'd2, 2'b01);
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            if (!busy) break;
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 16 || seen !== 1'b0) begin
            bad++;
            $display("FAIL fail_gen: busy cycles=%0d valid_seen=%b, want 16 0", n, seen);
        end
        total++;
        if (fail !== 1'b1 || rej_cnt !== 16'd16) begin
            bad++;
            $display("FAIL fail_flags: fail=%b rej=%0d, want 1 16", fail, rej_cnt);
        end
        @(negedge clk);
        total++;
        if (fail !== 1'b1) begin
            bad++;
            $display("FAIL fail_sticky: got %b, want 1", fail);
        end
        build(2'b10, 1);
        do_start(16'd1, 2'b10);
        total++;
        if (fail !== 1'b0) begin
            bad++;
            $display("FAIL fail_clear: got %b, want 0", fail);
        end
        collect(1, "after_fail");
    endtask

    task automatic test_backpressure;
        logic [14:0] ha;
        logic [11:0] hb;
        int w = 0;
        out_ready = 1'b0;
        build(2'b00, 2);
        do_start(16'd2, 2'b00);
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        ha = out_a;
        hb = out_b;
        total++;
        if (out_valid !== 1'b1 || ha !== exp_a[0] || hb !== exp_b[0]) begin
            bad++;
            $display("FAIL bp_first: valid=%b a=%h b=%h, want 1 %h %h", out_valid, ha, hb, exp_a[0], exp_b[0]);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_a !== ha || out_b !== hb) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%b a=%h b=%h, want 1 %h %h", i, out_valid, out_a, out_b, ha, hb);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_xfer: valid=%b busy=%b, want 0 1", out_valid, busy);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_a !== exp_a[1] || out_b !== exp_b[1]) begin
            bad++;
            $display("FAIL bp_second: valid=%b a=%h b=%h, want 1 %h %h", out_valid, out_a, out_b, exp_a[1], exp_b[1]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL bp_done: got %b, want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_count;
        logic seen = 1'b0;
        do_start(16'd0, 2'b00);
        total++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_done: done=%b busy=%b, want 1 1", done, busy);
        end
        start = 1'b1;
        count = 16'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid || busy || done) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL zero_ignore: activity seen=%b after ignored start, want 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        int w = 0;
        out_ready = 1'b0;
        do_start(16'd4, 2'b00);
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_a !== 0 || rej_cnt !== 0) begin
            bad++;
            $display("FAIL rst_mid: valid=%b busy=%b a=%h rej=%0d, want 0 0 0 0", out_valid, busy, out_a, rej_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        build(2'b00, 4);
        do_start(16'd4, 2'b00);
        collect(4, "restart");
    endtask

    initial begin
        test_reset;
        test_normal;
        test_force_a;
        test_fail;
        test_backpressure;
        test_zero_count;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
